// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, decode constants,
// byte-enable patterns and the stage FSM encoding.
package mem_stage_pkg;

   localparam int DW = 32;
   localparam int IW = 32;
   localparam int AW = 32;

   localparam logic [IW-1:0] NOP = 32'h0000_0013;

   // Major opcodes (inst[6:2])
   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;

   // funct3 for loads and stores (store uses B/H/W only)
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // Byte enables
   localparam logic [3:0] BE_B0 = 4'b0001;
   localparam logic [3:0] BE_B1 = 4'b0010;
   localparam logic [3:0] BE_B2 = 4'b0100;
   localparam logic [3:0] BE_B3 = 4'b1000;
   localparam logic [3:0] BE_LO = 4'b0011;
   localparam logic [3:0] BE_HI = 4'b1100;
   localparam logic [3:0] BE_W  = 4'b1111;

   typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

   // S-type immediate, sign-extended to DW
   function automatic logic [DW-1:0] imm_s(input logic [IW-1:0] i);
      return {{20{i[31]}}, i[31:25], i[11:7]};
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus. The stage is the master, the memory the slave.
interface mem_stage_if import mem_stage_pkg::*; ();
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                   input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                   output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for loads/stores: store data replication and byte
// enables, load byte/half extraction with sign/zero extension, plus the
// misalignment and illegal-funct3 checks. Purely combinational.
module mem_align import mem_stage_pkg::*; (
   input  logic          is_store,
   input  logic [2:0]    funct3,
   input  logic [1:0]    addr,
   input  logic [DW-1:0] store_data,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   output logic [DW-1:0] load_data,
   output logic          misaligned,
   output logic          illegal
);
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Lane selection and per-funct3 steering; word access is the default
   always_comb begin
      rd_byte    = mem_rdata[{addr, 3'b000} +: 8];
      rd_half    = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      mem_wdata  = store_data;
      mem_be     = BE_W;
      load_data  = mem_rdata;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (funct3)
         F3_B: begin
            load_data = {{24{rd_byte[7]}}, rd_byte};
            if (is_store) begin
               mem_wdata = {4{store_data[7:0]}};
               mem_be    = BE_B0 << addr;
            end
         end
         F3_H: begin
            load_data  = {{16{rd_half[15]}}, rd_half};
            misaligned = addr[0];
            if (is_store) begin
               mem_wdata = {2{store_data[15:0]}};
               mem_be    = addr[1] ? BE_HI : BE_LO;
            end
         end
         F3_W:  misaligned = (addr != 2'b00);
         F3_BU: begin
            load_data = {24'd0, rd_byte};
            illegal   = is_store;
         end
         F3_HU: begin
            load_data  = {16'd0, rd_half};
            misaligned = addr[0];
            illegal    = is_store;
         end
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one req/ack transaction per LOAD/STORE,
// passes everything else straight to the writeback output register.
module mem_stage import mem_stage_pkg::*; (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] inst,
   input  logic [DW-1:0] alu_result,
   input  logic [DW-1:0] base,
   input  logic [DW-1:0] store_data,
   mem_stage_if.master   bus,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] inst_o,
   output logic [DW-1:0] data_out,
   output logic          mem_err
);
   state_t        state_q, state_d;
   logic [IW-1:0] inst_q;
   logic [1:0]    ea_q;

   logic          is_load, is_store, is_mem, busy;
   logic [DW-1:0] ea;
   logic          accept, fault, mem_go, done;

   logic          al_store;
   logic [2:0]    al_f3;
   logic [1:0]    al_addr;
   logic [DW-1:0] al_wdata, al_load;
   logic [3:0]    al_be;
   logic          al_mis, al_ill;

   // rs1/rs2 register fields and the compressed-marker bits are not needed here
   logic          unused_inst;
   assign unused_inst = ^{inst[24:15], inst[1:0]};

   assign is_load  = (inst[6:2] == OP_LOAD);
   assign is_store = (inst[6:2] == OP_STORE);
   assign is_mem   = is_load | is_store;
   assign ea       = is_store ? base + imm_s(inst) : alu_result;
   assign busy     = (state_q == ST_ACCESS);

   assign in_ready = !busy && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign fault    = is_mem && (al_mis || al_ill);
   assign mem_go   = accept && is_mem && !fault;
   assign done     = busy && bus.mem_ack;

   // While idle the aligner checks the incoming access; while busy it
   // extracts load data using the latched instruction and address bits.
   assign al_store = busy ? (inst_q[6:2] == OP_STORE) : is_store;
   assign al_f3    = busy ? inst_q[14:12] : inst[14:12];
   assign al_addr  = busy ? ea_q : ea[1:0];

   mem_align u_align (
      .is_store   (al_store),
      .funct3     (al_f3),
      .addr       (al_addr),
      .store_data (store_data),
      .mem_rdata  (bus.mem_rdata),
      .mem_wdata  (al_wdata),
      .mem_be     (al_be),
      .load_data  (al_load),
      .misaligned (al_mis),
      .illegal    (al_ill)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: leave IDLE on a valid memory accept, return on ack
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (mem_go) state_d = ST_ACCESS;
         ST_ACCESS: if (bus.mem_ack) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Memory bus registers: loaded on accept, held stable until ack
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_be    <= '0;
         inst_q        <= NOP;
         ea_q          <= 2'b00;
      end else if (mem_go) begin
         bus.mem_req   <= 1'b1;
         bus.mem_we    <= is_store;
         bus.mem_addr  <= {ea[AW-1:2], 2'b00};
         bus.mem_wdata <= al_wdata;
         bus.mem_be    <= al_be;
         inst_q        <= inst;
         ea_q          <= ea[1:0];
      end else if (done) begin
         bus.mem_req   <= 1'b0;
      end
   end

   // Output register: capture pass-through/faults or a completed access,
   // otherwise drop valid once consumed and hold the payload
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         inst_o    <= NOP;
         data_out  <= '0;
         mem_err   <= 1'b0;
      end else if (accept && !mem_go) begin
         out_valid <= 1'b1;
         inst_o    <= inst;
         data_out  <= fault ? '0 : alu_result;
         mem_err   <= fault;
      end else if (done) begin
         out_valid <= 1'b1;
         inst_o    <= inst_q;
         data_out  <= (inst_q[6:2] == OP_STORE) ? '0 : al_load;
         mem_err   <= 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, faults,
// backpressure and reset during an outstanding access.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, mem_err;
   logic [31:0]   inst, alu_result, base, store_data, inst_o, data_out;
   int            errors = 0;
   int            checks = 0;

   mem_stage_if bus ();

   mem_stage dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .inst       (inst),
      .alu_result (alu_result),
      .base       (base),
      .store_data (store_data),
      .bus        (bus),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .inst_o     (inst_o),
      .data_out   (data_out),
      .mem_err    (mem_err)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ADD1 = 32'h0020_81B3;
   localparam logic [31:0] ADD2 = 32'h0031_0233;
   localparam logic [31:0] ADD3 = 32'h0041_82B3;
   localparam logic [31:0] LB   = 32'h0000_0083;
   localparam logic [31:0] LBU  = 32'h0000_4083;
   localparam logic [31:0] LW   = 32'h0000_2083;
   localparam logic [31:0] LF3  = 32'h0000_3083;
   localparam logic [31:0] SH6  = 32'h0000_1323;  // sh, imm = 6
   localparam logic [31:0] SBM1 = 32'hFE00_0FA3;  // sb, imm = -1

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      inst = 32'h0; alu_result = 32'h0; base = 32'h0; store_data = 32'h0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      tick(); tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_inst_o",    inst_o,             NOP);
      chk("rst_data_out",  data_out,           32'd0);
      chk("rst_mem_err",   {31'd0, mem_err},   32'd0);
      chk("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
      chk("rst_mem_be",    {28'd0, bus.mem_be},  32'd0);
      chk("rst_mem_addr",  bus.mem_addr,       32'd0);
      rst = 1'b0;

      // Pass-through ADDs stream at one per cycle
      in_valid = 1'b1; inst = ADD1; alu_result = 32'h7;
      #1 chk("add_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("add1_valid", {31'd0, out_valid}, 32'd1);
      chk("add1_data",  data_out, 32'h7);
      chk("add1_inst",  inst_o,   ADD1);
      chk("add1_noreq", {31'd0, bus.mem_req}, 32'd0);
      inst = ADD2; alu_result = 32'h9;
      tick();
      chk("add2_valid", {31'd0, out_valid}, 32'd1);
      chk("add2_data",  data_out, 32'h9);
      chk("add2_inst",  inst_o,   ADD2);
      in_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_hold",  data_out, 32'h9);

      // LB at 0x1003, ack on the third request cycle
      in_valid = 1'b1; inst = LB; alu_result = 32'h1003;
      tick();
      in_valid = 1'b0;
      chk("lb_req",    {31'd0, bus.mem_req}, 32'd1);
      chk("lb_addr",   bus.mem_addr, 32'h1000);
      chk("lb_be",     {28'd0, bus.mem_be}, 32'hF);
      chk("lb_we",     {31'd0, bus.mem_we}, 32'd0);
      chk("lb_busy",   {31'd0, in_ready}, 32'd0);
      tick();
      chk("lb_req2",   {31'd0, bus.mem_req}, 32'd1);
      tick();
      chk("lb_req3",   {31'd0, bus.mem_req}, 32'd1);
      chk("lb_addr3",  bus.mem_addr, 32'h1000);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FF_1234;
      tick();
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      chk("lb_valid",  {31'd0, out_valid}, 32'd1);
      chk("lb_data",   data_out, 32'hFFFF_FF80);
      chk("lb_inst",   inst_o, LB);
      chk("lb_reqoff", {31'd0, bus.mem_req}, 32'd0);

      // LBU with minimum latency (ack in the first request cycle)
      in_valid = 1'b1; inst = LBU; alu_result = 32'h1003;
      tick();
      in_valid = 1'b0;
      chk("lbu_req", {31'd0, bus.mem_req}, 32'd1);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FF_1234;
      tick();
      bus.mem_ack = 1'b0;
      chk("lbu_valid", {31'd0, out_valid}, 32'd1);
      chk("lbu_data",  data_out, 32'h0000_0080);

      // SH base 0x2000 + 6; alu_result must not matter for stores
      in_valid = 1'b1; inst = SH6; base = 32'h2000; alu_result = 32'h55;
      store_data = 32'hDEAD_BEEF;
      tick();
      in_valid = 1'b0;
      chk("sh_addr",  bus.mem_addr, 32'h2004);
      chk("sh_be",    {28'd0, bus.mem_be}, 32'hC);
      chk("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
      chk("sh_we",    {31'd0, bus.mem_we}, 32'd1);
      store_data = 32'h0;
      tick();
      chk("sh_hold_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      tick();
      bus.mem_ack = 1'b0;
      chk("sh_valid", {31'd0, out_valid}, 32'd1);
      chk("sh_data",  data_out, 32'h0);
      chk("sh_inst",  inst_o, SH6);

      // SB with negative offset: 0x2000 - 1 = 0x1FFF, top lane
      in_valid = 1'b1; inst = SBM1; base = 32'h2000; store_data = 32'h1122_3344;
      tick();
      in_valid = 1'b0;
      chk("sb_addr",  bus.mem_addr, 32'h1FFC);
      chk("sb_be",    {28'd0, bus.mem_be}, 32'h8);
      chk("sb_wdata", bus.mem_wdata, 32'h4444_4444);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("sb_done", {31'd0, out_valid}, 32'd1);

      // Misaligned LW and illegal LOAD funct3
      in_valid = 1'b1; inst = LW; alu_result = 32'h3002;
      tick();
      chk("lwmis_noreq", {31'd0, bus.mem_req}, 32'd0);
      chk("lwmis_valid", {31'd0, out_valid}, 32'd1);
      chk("lwmis_err",   {31'd0, mem_err}, 32'd1);
      chk("lwmis_data",  data_out, 32'h0);
      inst = LF3; alu_result = 32'h3000;
      tick();
      in_valid = 1'b0;
      chk("lf3_noreq", {31'd0, bus.mem_req}, 32'd0);
      chk("lf3_err",   {31'd0, mem_err}, 32'd1);
      chk("lf3_inst",  inst_o, LF3);
      chk("lf3_data",  data_out, 32'h0);

      // Backpressure: held entry blocks a new ADD until out_ready rises
      out_ready = 1'b0;
      in_valid = 1'b1; inst = ADD3; alu_result = 32'hAA;
      #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_inst",  inst_o, LF3);
      chk("bp_err",   {31'd0, mem_err}, 32'd1);
      out_ready = 1'b1;
      #1 chk("bp_release", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_new_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_new_inst",  inst_o, ADD3);
      chk("bp_new_data",  data_out, 32'hAA);
      chk("bp_new_err",   {31'd0, mem_err}, 32'd0);

      // Reset during an outstanding access; a late ack is ignored
      in_valid = 1'b1; inst = LW; alu_result = 32'h4000;
      tick();
      in_valid = 1'b0;
      chk("rstmid_req", {31'd0, bus.mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_reqoff", {31'd0, bus.mem_req}, 32'd0);
      chk("rstmid_valid",  {31'd0, out_valid}, 32'd0);
      chk("rstmid_inst",   inst_o, NOP);
      chk("rstmid_ready",  {31'd0, in_ready}, 32'd1);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
      tick();
      bus.mem_ack = 1'b0;
      chk("late_ack_valid", {31'd0, out_valid}, 32'd0);
      chk("late_ack_req",   {31'd0, bus.mem_req}, 32'd0);
      chk("late_ack_data",  data_out, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage in the 32-bit RISC-V pipeline.
- Consumes the executed instruction, ALU result and register operands.
- For LOAD/STORE: performs one variable-latency data-memory transaction over a req/ack bus, with byte-lane steering, sign/zero extension and misalignment detection.
- All other instructions pass through, registered, to the writeback stage.

Parameters:
DW, 32, data width (fixed at 32; byte lanes assume 4 bytes)
IW, 32, instruction width
AW, 32, data-memory byte-address width
NOP, 32'h00000013, instruction value driven on inst_o during reset

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage accepts the instruction this cycle (combinational)
inst  in  IW  executed instruction
alu_result  in  DW  execute result; load effective address for LOAD
base  in  DW  rs1 value; store base address
store_data  in  DW  rs2 value; store data
mem_req  out  1  data-memory request, held until acknowledged
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  word-aligned address, bits [1:0] = 0
mem_wdata  out  DW  lane-replicated write data
mem_be  out  4  byte enables
mem_rdata  in  DW  read data, valid while mem_ack = 1
mem_ack  in  1  one-cycle completion pulse
out_valid  out  1  result register holds a valid entry
out_ready  in  1  downstream consumes the entry this cycle
inst_o  out  IW  instruction for writeback
data_out  out  DW  writeback data
mem_err  out  1  access suppressed: misaligned address or illegal funct3

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, out_valid=0, inst_o=NOP, data_out=0, mem_err=0. FSM goes to IDLE.
- FSM states:
  - IDLE: no transaction outstanding.
  - ACCESS: mem_req=1, waiting for mem_ack.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An accept happens when in_valid && in_ready at a rising edge.
- Decode: opcode=inst[6:2].
  - LOAD=00000; funct3 LB=0, LH=1, LW=2, LBU=4, LHU=5.
  - STORE=01000; funct3 SB=0, SH=1, SW=2.
- Effective address EA:
  - LOAD: alu_result.
  - STORE: base + sext({inst[31:25], inst[11:7]}), modulo 2^32.
- Misaligned: half access with EA[0]=1, or word access with EA[1:0]!=0. Illegal: any other funct3 under LOAD/STORE.
- Non-memory accept (any opcode other than LOAD/STORE), or a faulting LOAD/STORE:
  - Next cycle: out_valid=1, inst_o=inst, state stays IDLE, no mem_req.
  - Non-memory: data_out=alu_result, mem_err=0.
  - Faulting LOAD/STORE: data_out=0, mem_err=1.
  - Latency: 1 cycle.
- Valid memory accept:
  - Next cycle: state=ACCESS, mem_req=1, mem_addr={EA[31:2],2'b00}, mem_we=(STORE).
  - Instruction and EA[1:0] are latched internally.
  - STORE lane rules:
    - SB: wdata={4{sd[7:0]}}, be=0001<<EA[1:0].
    - SH: wdata={2{sd[15:0]}}, be = EA[1] ? 1100 : 0011.
    - SW: wdata=sd, be=1111.
  - LOAD: be=1111.
  - mem_* outputs are stable while mem_req=1.
- ACCESS with mem_ack=1, at that edge:
  - mem_req=0, state=IDLE, out_valid=1, inst_o=latched instruction, mem_err=0.
  - LOAD data_out: byte/half selected by latched EA[1:0] from mem_rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW gives the full word.
  - STORE data_out: 0.
  - Minimum load latency: accept at N, mem_req at N+1, ack at N+1, out_valid at N+2.
- Output register:
  - out_valid && out_ready && no new capture: out_valid=0; inst_o, data_out and mem_err hold their values.
  - Consume and capture in the same cycle: new entry replaces the old one with no bubble.
  - out_valid && !out_ready: entry is held stable; in_ready=0.
- mem_ack while state==IDLE is ignored. mem_rdata is sampled only on mem_ack.
- Reset mid-transaction: mem_req drops at the reset edge and the pending access is abandoned. The memory side must not deliver a stale mem_ack after observing mem_req=0.
- Throughput:
  - Non-memory: 1 instruction/cycle while out_ready=1.
  - Memory: 1 access per (ack latency + 1) cycles.

Decomposition:
- Shared definitions include gains:
  - opcode/funct3 constants already used by execute (LOAD, STORE, LB..LHU, SB..SW);
  - byte-enable constants BE_B0..BE_B3, BE_LO, BE_HI, BE_W;
  - NOP encoding.
- One combinational sub-module, mem_align:
  - inputs: funct3, addr[1:0], store_data, mem_rdata;
  - outputs: mem_wdata, mem_be, load_data, misaligned, illegal.
  - Unit-testable on its own.
- FSM, handshake and output register stay in mem_stage.

Test Plan:
1. ADD inst, alu_result=0x0000_0007, out_ready=1 -> 1 cycle later out_valid=1, data_out=0x7, no mem_req; back-to-back ADDs stream at 1/cycle.
2. LB, alu_result=0x1003, ack after 3 cycles with rdata=0x80FF_1234 -> mem_addr=0x1000, be=1111, mem_req held 3 cycles, data_out=0xFFFF_FF80; the LBU variant gives 0x0000_0080.
3. SH, base=0x2000, imm_S=6, store_data=0xDEAD_BEEF -> mem_addr=0x2004, be=1100, wdata=0xBEEF_BEEF, we=1; on ack out_valid=1, data_out=0.
4. LW, alu_result=0x3002 -> no mem_req, next cycle out_valid=1, mem_err=1, data_out=0; LOAD funct3=3 gives the same result.
5. out_ready=0 with an entry held, new ADD presented -> in_ready=0, outputs stable; raising out_ready -> held entry consumed and new one accepted that cycle, next cycle's output is the ADD.
6. rst=1 while in ACCESS (mem_req=1) -> next cycle mem_req=0, out_valid=0, inst_o=0x0000_0013, in_ready=1; a late mem_ack is ignored.
